// File: rtl/dds_pkg.sv
// Shared constants, widths and types for the DDS waveform generator.
package dds_pkg;

    localparam int ACC_W  = 32;
    localparam int IDX_W  = 12;
    localparam int ADDR_W = 14;

    localparam logic [1:0] SINE     = 2'd0;
    localparam logic [1:0] SQUARE   = 2'd1;
    localparam logic [1:0] TRIANGLE = 2'd2;
    localparam logic [1:0] SAW      = 2'd3;

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } sw_state_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] code;
    } wave_req_t;

    // Only a strictly one-hot request is meaningful; anything else is flagged invalid.
    function automatic wave_req_t decode_sel(input logic [3:0] sel);
        wave_req_t r;
        r.valid = 1'b1;
        r.code  = SINE;
        case (sel)
            4'b0001: r.code  = SINE;
            4'b0010: r.code  = SQUARE;
            4'b0100: r.code  = TRIANGLE;
            4'b1000: r.code  = SAW;
            default: r.valid = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dds_phase_acc.sv
// Free-running phase accumulator with overflow pulse and offset table index.
module dds_phase_acc
    import dds_pkg::*;
#(
    parameter logic [ACC_W-1:0] FREQ_CTRL  = 32'd42949,
    parameter logic [IDX_W-1:0] PHASE_CTRL = 12'd1024
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    output logic [IDX_W-1:0] o_index,
    output logic             o_phase_wrap
);

    logic [ACC_W-1:0] r_acc;
    logic [IDX_W-1:0] r_index;
    logic             r_phase_wrap;
    logic [ACC_W:0]   w_sum;

    assign w_sum = {1'b0, r_acc} + {1'b0, FREQ_CTRL};

    // The index is taken from the accumulator value before this edge's add,
    // so it trails acc by one cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc        <= '0;
            r_index      <= '0;
            r_phase_wrap <= 1'b0;
        end else begin
            r_acc        <= w_sum[ACC_W-1:0];
            r_phase_wrap <= w_sum[ACC_W];
            r_index      <= r_acc[ACC_W-1 -: IDX_W] + PHASE_CTRL;
        end
    end

    assign o_index      = r_index;
    assign o_phase_wrap = r_phase_wrap;

endmodule

// File: rtl/dds_wave_gen.sv
// DDS waveform ROM addresser. Define DDS_SYNC_SWITCH_EN to defer waveform
// changes to the next phase wrap; otherwise changes apply on the next clock.
module dds_wave_gen
    import dds_pkg::*;
#(
    parameter logic [ACC_W-1:0] FREQ_CTRL  = 32'd42949,
    parameter logic [IDX_W-1:0] PHASE_CTRL = 12'd1024
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [3:0]        wave_sel,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [1:0]        wave_id,
    output logic              phase_wrap,
    output logic              switch_pend
);

    logic [IDX_W-1:0] w_index;
    logic             w_phase_wrap;
    wave_req_t        w_req;
    logic [1:0]       r_wave_id;

    dds_phase_acc #(
        .FREQ_CTRL  (FREQ_CTRL),
        .PHASE_CTRL (PHASE_CTRL)
    ) u_phase_acc (
        .i_clk        (sys_clk),
        .i_rst_n      (sys_rst_n),
        .o_index      (w_index),
        .o_phase_wrap (w_phase_wrap)
    );

    assign w_req = decode_sel(wave_sel);

`ifdef DDS_SYNC_SWITCH_EN
    sw_state_t  r_state;
    logic [1:0] r_pend_id;

    // A wrap always wins over a same-cycle request; that request is re-seen in RUN.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state   <= RUN;
            r_wave_id <= SINE;
            r_pend_id <= SINE;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_req.valid && (w_req.code != r_wave_id)) begin
                        r_pend_id <= w_req.code;
                        r_state   <= PEND;
                    end
                end
                PEND: begin
                    if (w_phase_wrap) begin
                        r_wave_id <= r_pend_id;
                        r_state   <= RUN;
                    end else if (w_req.valid) begin
                        if (w_req.code == r_wave_id) begin
                            r_state <= RUN;
                        end else begin
                            r_pend_id <= w_req.code;
                        end
                    end
                end
            endcase
        end
    end

    assign switch_pend = (r_state == PEND);
`else
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_wave_id <= SINE;
        end else if (w_req.valid) begin
            r_wave_id <= w_req.code;
        end
    end

    assign switch_pend = 1'b0;
`endif

    assign rom_addr   = {r_wave_id, w_index};
    assign wave_id    = r_wave_id;
    assign phase_wrap = w_phase_wrap;

endmodule

// File: tb/tb_dds_wave_gen.sv
// Scoreboard bench for dds_wave_gen: two instances (phase offset 0 and 4095)
// share clock, reset and wave_sel; expectations follow DDS_SYNC_SWITCH_EN.
module tb_dds_wave_gen;

    localparam logic [31:0] FREQ = 32'h1000_0000;
`ifdef DDS_SYNC_SWITCH_EN
    localparam bit SYNC = 1'b1;
`else
    localparam bit SYNC = 1'b0;
`endif

    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [3:0]  wave_sel  = 4'b0000;

    logic [13:0] a_rom_addr, b_rom_addr;
    logic [1:0]  a_wave_id, b_wave_id;
    logic        a_phase_wrap, b_phase_wrap;
    logic        a_switch_pend, b_switch_pend;

    dds_wave_gen #(.FREQ_CTRL(FREQ), .PHASE_CTRL(12'd0)) dut_a (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .wave_sel    (wave_sel),
        .rom_addr    (a_rom_addr),
        .wave_id     (a_wave_id),
        .phase_wrap  (a_phase_wrap),
        .switch_pend (a_switch_pend)
    );

    dds_wave_gen #(.FREQ_CTRL(FREQ), .PHASE_CTRL(12'd4095)) dut_b (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .wave_sel    (wave_sel),
        .rom_addr    (b_rom_addr),
        .wave_id     (b_wave_id),
        .phase_wrap  (b_phase_wrap),
        .switch_pend (b_switch_pend)
    );

    // clock
    always #5 sys_clk = ~sys_clk;

    // scoreboard state: {rom_addr, wave_id, phase_wrap, switch_pend}
    logic [17:0] exp_a_q[$];
    logic [17:0] exp_b_q[$];
    int checks = 0;
    int errors = 0;
    int n_edge = 0;

    // n = rising edges since reset release; acc before edge n is (n-1)*2^28.
    function automatic logic [17:0] pack_exp(input int n, input logic [11:0] p,
                                             input logic [1:0] id, input logic pend);
        logic [11:0] idx;
        logic        wrap;
        if (n == 0) begin
            idx  = 12'd0;
            wrap = 1'b0;
        end else begin
            idx  = 12'((n - 1) * 256) + p;
            wrap = (n % 16 == 0);
        end
        return {id, idx, id, wrap, pend};
    endfunction

    task automatic compare(input string name, input logic [17:0] act, input logic [17:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got rom_addr=%h wave_id=%0d phase_wrap=%0b switch_pend=%0b, expected rom_addr=%h wave_id=%0d phase_wrap=%0b switch_pend=%0b",
                     name, $time, act[17:4], act[3:2], act[1], act[0],
                     exp[17:4], exp[3:2], exp[1], exp[0]);
        end
    endtask

    // driver: s_* = expected with wrap-synchronous switching, a_id = immediate switching
    task automatic step(input logic rst, input logic [3:0] sel, input logic [1:0] s_id,
                        input logic s_pend, input logic [1:0] a_id);
        logic [1:0] id;
        logic       pend;
        @(negedge sys_clk);
        sys_rst_n = rst;
        wave_sel  = sel;
        n_edge    = rst ? n_edge + 1 : 0;
        id   = SYNC ? s_id : a_id;
        pend = SYNC ? s_pend : 1'b0;
        if (!rst) begin
            id   = 2'd0;
            pend = 1'b0;
        end
        exp_a_q.push_back(pack_exp(n_edge, 12'd0, id, pend));
        exp_b_q.push_back(pack_exp(n_edge, 12'd4095, id, pend));
    endtask

    task automatic run(input int count, input logic rst, input logic [3:0] sel,
                       input logic [1:0] s_id, input logic s_pend, input logic [1:0] a_id);
        for (int i = 0; i < count; i++) step(rst, sel, s_id, s_pend, a_id);
    endtask

    // monitor
    initial begin
        forever begin
            @(posedge sys_clk);
            #2;
            if (exp_a_q.size() != 0) compare("dut_a", {a_rom_addr, a_wave_id, a_phase_wrap, a_switch_pend}, exp_a_q.pop_front());
            if (exp_b_q.size() != 0) compare("dut_b", {b_rom_addr, b_wave_id, b_phase_wrap, b_switch_pend}, exp_b_q.pop_front());
        end
    end

    initial begin
        //   count rst sel      s_id s_pend a_id
        run(3,  1'b0, 4'b0001, 2'd0, 1'b0, 2'd0);   // held in reset
        run(32, 1'b1, 4'b0001, 2'd0, 1'b0, 2'd0);   // edges 1..32: stepping, wraps at 16, 32
        run(3,  1'b1, 4'b0000, 2'd0, 1'b0, 2'd0);   // 33..35
        run(1,  1'b1, 4'b0010, 2'd0, 1'b1, 2'd1);   // 36: request square
        run(1,  1'b1, 4'b0001, 2'd0, 1'b0, 2'd0);   // 37: back to current -> cancel
        run(1,  1'b1, 4'b0000, 2'd0, 1'b0, 2'd0);   // 38
        run(1,  1'b1, 4'b0110, 2'd0, 1'b0, 2'd0);   // 39: two bits set, ignored
        run(1,  1'b1, 4'b0000, 2'd0, 1'b0, 2'd0);   // 40
        run(1,  1'b1, 4'b1111, 2'd0, 1'b0, 2'd0);   // 41: ignored
        run(1,  1'b1, 4'b0010, 2'd0, 1'b1, 2'd1);   // 42: request square mid-period
        run(2,  1'b1, 4'b0000, 2'd0, 1'b1, 2'd1);   // 43..44
        run(1,  1'b1, 4'b0110, 2'd0, 1'b1, 2'd1);   // 45: invalid while pending, kept
        run(3,  1'b1, 4'b0000, 2'd0, 1'b1, 2'd1);   // 46..48: wrap pulse at 48
        run(4,  1'b1, 4'b0000, 2'd1, 1'b0, 2'd1);   // 49..52: committed
        run(1,  1'b1, 4'b0100, 2'd1, 1'b1, 2'd2);   // 53: request triangle
        run(1,  1'b1, 4'b1000, 2'd1, 1'b1, 2'd3);   // 54: overwrite with sawtooth
        run(10, 1'b1, 4'b0000, 2'd1, 1'b1, 2'd3);   // 55..64: wrap pulse at 64
        run(1,  1'b1, 4'b0100, 2'd3, 1'b0, 2'd2);   // 65: commit saw, request waits
        run(1,  1'b1, 4'b0100, 2'd3, 1'b1, 2'd2);   // 66: request seen in RUN
        run(14, 1'b1, 4'b0000, 2'd3, 1'b1, 2'd2);   // 67..80: wrap pulse at 80
        run(2,  1'b1, 4'b0000, 2'd2, 1'b0, 2'd2);   // 81..82: triangle committed
        run(1,  1'b1, 4'b1000, 2'd2, 1'b1, 2'd3);   // 83: pending saw
        run(2,  1'b0, 4'b0000, 2'd0, 1'b0, 2'd0);   // reset mid-pend
        run(20, 1'b1, 4'b0000, 2'd0, 1'b0, 2'd0);   // fresh run, pending change gone

        for (int i = 0; i < 10 && (exp_a_q.size() != 0 || exp_b_q.size() != 0); i++)
            @(posedge sys_clk);
        #3;
        checks++;
        if (exp_a_q.size() != 0 || exp_b_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d/%0d expectations left, expected 0",
                     exp_a_q.size(), exp_b_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dds_wave_gen.md
DDS_WAVE_GEN -- requirements
Module: dds_wave_gen

Interface
REQ-001 Parameter FREQ_CTRL, default 32'd42949, is the phase increment per clock (about 500 Hz at 50 MHz).
REQ-002 Parameter PHASE_CTRL, default 12'd1024, is the phase offset added to the table index (90 degrees).
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset:
- Port sys_clk  input  1  system clock, 50 MHz.
- Port sys_rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port wave_sel  input  4  one-hot waveform request from the key controller: 0001 sine, 0010 square, 0100 triangle, 1000 sawtooth.
REQ-005 Port rom_addr  output  14  registered waveform ROM address {wave_id, index[11:0]}.
REQ-006 Port wave_id  output  2  registered active waveform code: 0 sine, 1 square, 2 triangle, 3 sawtooth.
REQ-007 Port phase_wrap  output  1  registered one-cycle pulse on accumulator overflow.
REQ-008 Port switch_pend  output  1  registered flag, high while a waveform change waits for a phase wrap.

Function
REQ-009 The 32-bit accumulator acc SHALL add FREQ_CTRL every clock, modulo 2^32, starting from 0 after reset.
REQ-010 phase_wrap SHALL be 1 in the cycle after any add whose 33-bit sum exceeds 32'hFFFF_FFFF, otherwise 0.
REQ-011 The index SHALL be (acc[31:20] + PHASE_CTRL) mod 4096, registered one cycle after acc.
REQ-012 rom_addr SHALL be {wave_id, index} with one cycle of latency from acc.
REQ-013 wave_sel SHALL decode to a 2-bit code only when exactly one bit is set.
REQ-014 A wave_sel value of 0000, or one with more than one bit set, SHALL be ignored, and current and pending codes are kept.
REQ-015 The switch FSM SHALL have states RUN and PEND; in RUN, a valid code different from wave_id moves it to PEND and latches that code as pend_id.
REQ-016 In PEND, a new valid code different from wave_id SHALL overwrite pend_id.
REQ-017 In PEND, a valid code equal to wave_id SHALL cancel the change and return the FSM to RUN, with wave_id unchanged.
REQ-018 In PEND, the cycle that asserts phase_wrap SHALL load wave_id from pend_id and return to RUN.
REQ-019 If a new request arrives in the same cycle as a wrap, the wrap SHALL commit the old pend_id, and the new request is evaluated in RUN on the next cycle.
REQ-020 switch_pend SHALL be 1 exactly while the FSM is in PEND.
REQ-021 acc SHALL never stall or reset on a waveform change.

Reset
REQ-022 While sys_rst_n is 0, the following SHALL hold: acc=0, index=0, rom_addr=14'd0, wave_id=2'd0, pend_id=2'd0, phase_wrap=0, switch_pend=0, FSM in RUN.
REQ-023 Reset asserted mid-PEND SHALL discard the pending change.
REQ-024 The first acc increment SHALL occur on the first sys_clk rising edge after reset is released.

Configuration
REQ-025 Macro DDS_SYNC_SWITCH_EN, when defined, SHALL enable the wrap-synchronous switching of REQ-015..REQ-020.
REQ-026 With DDS_SYNC_SWITCH_EN undefined, a valid code SHALL load wave_id on the next clock, switch_pend is tied 0, and the FSM and pend_id are not built.

Structure
REQ-027 Package dds_pkg SHALL hold:
- the wave code constants SINE=0, SQUARE=1, TRIANGLE=2, SAW=3;
- the widths ACC_W=32, IDX_W=12, ADDR_W=14;
- the FSM state typedef {RUN, PEND}.
REQ-028 Sub-module dds_phase_acc SHALL contain acc, the carry/phase_wrap logic and the index register.
REQ-029 The decode logic and the FSM SHALL stay in dds_wave_gen.

Verification (FREQ_CTRL=32'h1000_0000, PHASE_CTRL=12'd0 unless stated)
REQ-030 Reset, then run 32 cycles:
- rom_addr low bits step by 256 each cycle;
- phase_wrap pulses every 16th cycle;
- the first pulse comes 16 clocks after reset release.
REQ-031 With the macro on, drive wave_sel=0010 for 1 cycle mid-period:
- switch_pend rises the next cycle;
- wave_id becomes 1 on the next phase_wrap;
- rom_addr[13:12]=01 from the following cycle.
REQ-032 With the macro on, drive 0010 and then 0001 while in PEND: switch_pend falls and wave_id stays 0.
REQ-033 Drive 0110, then 0000: no state change and switch_pend stays 0.
REQ-034 With the macro undefined, drive 1000: wave_id=3 one cycle later, regardless of phase.
REQ-035 With PHASE_CTRL=12'd4095 and acc=0 at reset: the first index is 4095 and the next index is (256+4095) mod 4096 = 255.
